frame_read_sched: RTL and testbench

- Sequences DDR frame-buffer reads that feed the HDMI pixel FIFO. The FIFO is drained by pix_req/pix_data on the display side.
- On each display frame start, the block flushes the FIFO, selects the read bank (double-buffered against the writer), and walks V_ACT lines.
- Each line is fetched as a series of bursts, issued only when the FIFO has room. One read is outstanding at a time.
- Sits in the DDR user-clock domain between the video timing generator (frame_start already synchronized) and the DDR read port.

---
 rtl/frame_sched_pkg.sv | 17 +
 rtl/frame_addr_gen.sv | 49 ++++
 rtl/frame_read_sched.sv | 151 +++++++++++++++
 tb/tb_frame_read_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared scheduler state encoding, 1080p defaults and burst sizing helpers
package frame_sched_pkg;
    localparam int DEF_H_ACT        = 1920;
    localparam int DEF_V_ACT        = 1080;
    localparam int DEF_PIX_PER_WORD = 8;
    localparam int DEF_BURST_LEN    = 64;
    localparam int DEF_LINE_STRIDE  = 256;
    localparam int DEF_BANK_SIZE    = 'h44000;
    localparam int DEF_FIFO_DEPTH   = 1024;
    typedef enum logic [2:0] {IDLE, WAIT_FRAME, FLUSH, CHECK, REQ, XFER} state_e;
    function automatic int words_per_line(input int h_act, input int ppw);
        return h_act / ppw;
    endfunction
    function automatic int burst_words(input int max_burst, input int remaining);
        return (remaining < max_burst) ? remaining : max_burst;
    endfunction
endpackage

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: line/word accumulators producing the next burst address and length
module frame_addr_gen import frame_sched_pkg::*; #(
    parameter int ADDR_W       = 28,
    parameter int H_ACT        = DEF_H_ACT,
    parameter int V_ACT        = DEF_V_ACT,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int LINE_STRIDE  = DEF_LINE_STRIDE,
    parameter int BASE_ADDR    = 0,
    parameter int BANK_SIZE    = DEF_BANK_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic              bank,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        len,
    output logic              frame_end
);
    localparam int WPL = words_per_line(H_ACT, PIX_PER_WORD);
    localparam logic [ADDR_W-1:0] BANK0 = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BANK1 = ADDR_W'(BASE_ADDR + BANK_SIZE);
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              line_end;
    // line_base_q tracks line_cnt*LINE_STRIDE so no multiplier sits in the request path
    always_comb begin
        len         = 8'(burst_words(BURST_LEN, WPL - int'(word_cnt_q)));
        line_end    = (int'(word_cnt_q) + int'(len)) == WPL;
        frame_end   = line_end && (int'(line_cnt_q) == V_ACT - 1);
        addr        = (bank ? BANK1 : BANK0) + line_base_q + ADDR_W'(word_cnt_q);
        word_cnt_d  = clr ? '0 : !adv ? word_cnt_q : line_end ? '0 : word_cnt_q + 16'(len);
        line_cnt_d  = clr ? '0 : (adv && line_end) ? line_cnt_q + 16'd1 : line_cnt_q;
        line_base_d = clr ? '0 : (adv && line_end) ? line_base_q + ADDR_W'(LINE_STRIDE) : line_base_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_base_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_base_q <= line_base_d;
        end
    end
endmodule

// File: rtl/frame_read_sched.sv
// frame_read_sched: sequences double-buffered DDR frame reads into the HDMI pixel FIFO
module frame_read_sched import frame_sched_pkg::*; #(
    parameter int ADDR_W       = 28,
    parameter int H_ACT        = DEF_H_ACT,
    parameter int V_ACT        = DEF_V_ACT,
    parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int LINE_STRIDE  = DEF_LINE_STRIDE,
    parameter int BASE_ADDR    = 0,
    parameter int BANK_SIZE    = DEF_BANK_SIZE,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int LVL_W        = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr_init_done,
    input  logic              frame_start,
    input  logic              wr_frame_done,
    input  logic [LVL_W-1:0]  fifo_wr_level,
    output logic              fifo_flush,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              rd_bank,
    output logic              busy,
    output logic              frame_overrun
);
    state_e            state_q, state_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic              rd_bank_q, rd_bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic              restart_pending_q, restart_pending_d;
    logic              frame_overrun_q, frame_overrun_d;
    logic              clr, adv, swap_now, room, frame_end;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        next_len;

    frame_addr_gen #(
        .ADDR_W(ADDR_W), .H_ACT(H_ACT), .V_ACT(V_ACT), .PIX_PER_WORD(PIX_PER_WORD),
        .BURST_LEN(BURST_LEN), .LINE_STRIDE(LINE_STRIDE), .BASE_ADDR(BASE_ADDR),
        .BANK_SIZE(BANK_SIZE)
    ) u_addr (
        .clk(clk), .rst(rst), .clr(clr), .adv(adv), .bank(rd_bank_q),
        .addr(next_addr), .len(next_len), .frame_end(frame_end)
    );

    assign fifo_flush    = state_q == FLUSH;
    assign busy          = state_q inside {FLUSH, CHECK, REQ, XFER};
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign rd_len        = rd_len_q;
    assign rd_bank       = rd_bank_q;
    assign frame_overrun = frame_overrun_q;

    always_comb begin
        state_d           = state_q;
        rd_req_d          = rd_req_q;
        rd_addr_d         = rd_addr_q;
        rd_len_d          = rd_len_q;
        rd_bank_d         = rd_bank_q;
        swap_pending_d    = swap_pending_q | wr_frame_done;
        restart_pending_d = restart_pending_q;
        frame_overrun_d   = frame_start & busy;
        clr               = 1'b0;
        adv               = 1'b0;
        swap_now          = swap_pending_q | wr_frame_done;
        room              = (int'(fifo_wr_level) + int'(next_len)) <= FIFO_DEPTH;
        case (state_q)
            IDLE: state_d = ddr_init_done ? WAIT_FRAME : IDLE;
            WAIT_FRAME: begin
                if (!ddr_init_done) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    state_d        = FLUSH;
                    rd_bank_d      = rd_bank_q ^ swap_now;
                    swap_pending_d = 1'b0;
                end
            end
            FLUSH: begin
                clr               = 1'b1;
                restart_pending_d = 1'b0;
                state_d           = ddr_init_done ? CHECK : IDLE;
            end
            CHECK: begin
                if (!ddr_init_done) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    state_d        = FLUSH;
                    rd_bank_d      = rd_bank_q ^ swap_now;
                    swap_pending_d = 1'b0;
                end else if (room) begin
                    state_d   = REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = next_addr;
                    rd_len_d  = next_len;
                end
            end
            REQ: begin
                if (frame_start) restart_pending_d = 1'b1;
                if (rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (frame_start) restart_pending_d = 1'b1;
                if (rd_done) begin
                    adv = 1'b1;
                    if (!ddr_init_done) begin
                        state_d           = IDLE;
                        restart_pending_d = 1'b0;
                    end else if (restart_pending_q || frame_start) begin
                        state_d           = FLUSH;
                        rd_bank_d         = rd_bank_q ^ swap_now;
                        swap_pending_d    = 1'b0;
                        restart_pending_d = 1'b0;
                    end else begin
                        state_d = frame_end ? WAIT_FRAME : CHECK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            rd_req_q          <= 1'b0;
            rd_addr_q         <= '0;
            rd_len_q          <= '0;
            rd_bank_q         <= 1'b0;
            swap_pending_q    <= 1'b0;
            restart_pending_q <= 1'b0;
            frame_overrun_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            rd_req_q          <= rd_req_d;
            rd_addr_q         <= rd_addr_d;
            rd_len_q          <= rd_len_d;
            rd_bank_q         <= rd_bank_d;
            swap_pending_q    <= swap_pending_d;
            restart_pending_q <= restart_pending_d;
            frame_overrun_q   <= frame_overrun_d;
        end
    end
endmodule

// File: tb/tb_frame_read_sched.sv
// tb_frame_read_sched: directed checks of burst sequencing, flow control, bank swap and overrun
module tb_frame_read_sched;
    import frame_sched_pkg::*;
    logic        clk = 0, rst = 1, ddr_init_done = 0, frame_start = 0, wr_frame_done = 0;
    logic        rd_ack = 0, rd_done = 0;
    logic [10:0] fifo_wr_level = '0;
    logic        fifo_flush, rd_req, rd_bank, busy, frame_overrun;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic        seen;
    int          n_cmp = 0, n_bad = 0;

    frame_read_sched #(.V_ACT(2)) dut (
        .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done), .frame_start(frame_start),
        .wr_frame_done(wr_frame_done), .fifo_wr_level(fifo_wr_level), .fifo_flush(fifo_flush),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
        .rd_bank(rd_bank), .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input int limit);
        int k = 0;
        while (!rd_req && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", rd_req, 1);
    endtask

    task automatic serve(input logic [27:0] a, input logic [7:0] l);
        wait_req(100);
        chk("rd_addr", rd_addr, a);
        chk("rd_len", rd_len, l);
        rd_ack = 1;
        @(negedge clk);
        rd_ack = 0;
        chk("req_drop", rd_req, 0);
        repeat (9) @(negedge clk);
        rd_done = 1;
        @(negedge clk);
        rd_done = 0;
    endtask

    task automatic serve_frame(input logic [27:0] base);
        for (int ln = 0; ln < 2; ln++)
            for (int w = 0; w < 4; w++)
                serve(base + 28'(ln * 256 + w * 64), (w == 3) ? 8'd48 : 8'd64);
    endtask

    task automatic pulse_fs;
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", rd_req, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bank", rd_bank, 0);
        chk("rst_ovr", frame_overrun, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_len", rd_len, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_no_init", dut.state_q, IDLE);
        ddr_init_done = 1;
        @(negedge clk);
        chk("wait_frame", dut.state_q, WAIT_FRAME);
        // first frame: latency then 8 bursts over 2 lines
        pulse_fs;
        chk("flush_n1", fifo_flush, 1);
        chk("req_n1", rd_req, 0);
        chk("busy_n1", busy, 1);
        @(negedge clk);
        chk("flush_n2", fifo_flush, 0);
        chk("req_n2", rd_req, 0);
        @(negedge clk);
        chk("req_n3", rd_req, 1);
        serve_frame(28'h0);
        chk("frame_end_busy", busy, 0);
        chk("frame_end_state", dut.state_q, WAIT_FRAME);
        repeat (5) @(negedge clk);
        chk("frame_end_noreq", rd_req, 0);
        // FIFO nearly full holds off requests
        fifo_wr_level = 11'd980;
        pulse_fs;
        repeat (12) @(negedge clk);
        chk("full_noreq", rd_req, 0);
        chk("full_state", dut.state_q, CHECK);
        fifo_wr_level = 11'd960;
        @(negedge clk);
        chk("room_req", rd_req, 1);
        chk("room_addr", rd_addr, 0);
        fifo_wr_level = 11'd0;
        // overrun during XFER with a pending swap
        rd_ack = 1;
        @(negedge clk);
        rd_ack = 0;
        wr_frame_done = 1;
        @(negedge clk);
        wr_frame_done = 0;
        @(negedge clk);
        wr_frame_done = 1;
        @(negedge clk);
        wr_frame_done = 0;
        pulse_fs;
        chk("ovr_pulse", frame_overrun, 1);
        @(negedge clk);
        chk("ovr_once", frame_overrun, 0);
        repeat (6) @(negedge clk);
        chk("ovr_noreq", rd_req, 0);
        chk("ovr_noflush", fifo_flush, 0);
        chk("ovr_xfer", dut.state_q, XFER);
        rd_done = 1;
        @(negedge clk);
        rd_done = 0;
        chk("ovr_flush", fifo_flush, 1);
        chk("ovr_bank", rd_bank, 1);
        serve_frame(28'h44000);
        chk("bank1_end", dut.state_q, WAIT_FRAME);
        // swap request coincident with frame_start
        wr_frame_done = 1;
        frame_start = 1;
        @(negedge clk);
        wr_frame_done = 0;
        frame_start = 0;
        chk("same_cycle_bank", rd_bank, 0);
        serve(28'h0, 8'd64);
        // DDR goes down while a request is pending
        wait_req(20);
        chk("down_addr", rd_addr, 64);
        ddr_init_done = 0;
        repeat (3) @(negedge clk);
        chk("down_req_hold", rd_req, 1);
        chk("down_addr_hold", rd_addr, 64);
        rd_ack = 1;
        @(negedge clk);
        rd_ack = 0;
        chk("down_req_drop", rd_req, 0);
        repeat (9) @(negedge clk);
        rd_done = 1;
        @(negedge clk);
        rd_done = 0;
        chk("down_idle", dut.state_q, IDLE);
        chk("down_busy", busy, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req) seen = 1;
        end
        chk("down_noreq", seen, 0);
        // reset in the middle of a request
        ddr_init_done = 1;
        @(negedge clk);
        pulse_fs;
        wait_req(10);
        rst = 1;
        @(negedge clk);
        chk("midrst_req", rd_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", dut.state_q, IDLE);
        rst = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
